rob: RTL and testbench
======================

# rob

Reorder buffer sitting directly downstream of the rename stage. It accepts renamed instructions (`di_t`) in program order and allocates one entry per instruction. It marks entries completed on writeback and retires them in order, one per cycle. Its commit port drives the `rob_entry_t` that rename consumes to release physical registers.

## Interface
- `ROB_SIZE`, default 16: number of entries; power of two, at least 2.
- `ROB_ID_BITS`, default `$clog2(ROB_SIZE)`: entry index width (derived; do not override).
- `clk`  in  1  clock.
- `rstn`  in  1  reset: synchronous, active-low.
- `di_i`  in  `di_t`  renamed instruction from rename (`di_o` there).
- `di_i_valid`  in  1  instruction present.
- `di_i_ready`  out  1  entry available; allocation happens when `di_i_valid && di_i_ready`.
- `rob_id_o`  out  `ROB_ID_BITS`  index that the current `di_i` is allocated to (= tail index).
- `wb_valid_i`  in  1  execution writeback strobe.
- `wb_rob_id_i`  in  `ROB_ID_BITS`  entry being completed.
- `flush_i`  in  1  discard all entries.
- `commit_entry_o`  out  `rob_entry_t`  head entry; `.completed` high only on a commit cycle.
- `count_o`  out  `ROB_ID_BITS+1`  occupied entries, 0..`ROB_SIZE`.

## Operation
- Storage: per entry `valid`, `completed`, `id`, `pc`, `rd`, `prd`, `needprf2arf` (= `si.rd_valid`), `fault`.
- Pointers: `head_q` and `tail_q`, each `ROB_ID_BITS+1` bits wide (MSB = wrap bit).
  - Empty: pointers equal.
  - Full: index bits equal and wrap bits differ.
  - `count_o` = `tail_q - head_q`, modulo 2^(`ROB_ID_BITS`+1).
- Allocate:
  - `di_i_ready = !full && !flush_i`.
  - On fire, entry[tail] is written with `valid=1`, `completed=0`, and the fields from `di_i`; `tail_q` increments.
- Writeback:
  - When `wb_valid_i` is high and entry[`wb_rob_id_i`] is valid, set `completed=1`.
  - A writeback to an invalid entry is ignored and fires an assertion.
  - A writeback to an already-completed entry is idempotent.
- Commit:
  - Commit happens when entry[head] is valid and completed and `flush_i` is low.
  - On commit, `commit_entry_o` reflects entry[head] with `.completed=1`, entry[head].valid is cleared, and `head_q` increments.
  - On every other cycle, `commit_entry_o` carries the head fields with `.completed=0`.
  - This guarantees rename never frees a register spuriously.
- Faulting entries commit normally with `.fault` set; redirect is handled outside this block.
- Flush:
  - `flush_i` clears every `valid`/`completed` bit and sets `head_q = tail_q = 0`.
  - It has priority over allocate, writeback and commit in the same cycle: none of those take effect.
- Simultaneous allocate and commit: both take effect and `count_o` is unchanged.
- Simultaneous writeback and commit of different entries: both take effect.

## Timing
- Reset values:
  - `head_q = tail_q = 0`; all `valid`/`completed` = 0.
  - `di_i_ready` = 1 (when `flush_i`=0); `rob_id_o` = 0; `count_o` = 0.
  - `commit_entry_o.completed` = 0.
- `di_i_ready`, `rob_id_o`, `commit_entry_o` and `count_o` are combinational from registered state, except that `di_i_ready` also depends on `flush_i`.
- None of these outputs depend on `di_i_valid`, so there is no combinational loop with rename.
- Allocation at cycle t: entry visible at t+1.
- Writeback at t: completed at t+1; commit at t+1 if the entry is at head.
- Minimum latency from allocation to commit is 2 cycles. Throughput is one allocation and one commit per cycle.
- When full, `di_i_ready` stays 0 even if a commit occurs in that cycle; the freed slot is usable at t+1.
- A reset asserted mid-operation discards all state at the next edge; no commit is emitted in the reset cycle.

## Configuration
- `ROB_TRACE_EN` defined:
  - Prints one `$display` line per allocation, writeback and commit: pc, id, rob index, rd, prd, fault.
  - Adds a per-cycle assertion that `count_o` ≤ `ROB_SIZE`, plus the invalid-writeback assertion.
- `ROB_TRACE_EN` undefined:
  - No display or assertion code is compiled.
  - Functional behaviour is identical.

## Test plan
- Reset, then idle: `di_i_ready`=1, `count_o`=0, `rob_id_o`=0, `commit_entry_o.completed`=0 for 10 cycles.
- Allocate 3 instructions (rd_valid=1, prd 5/6/7), then write back ids 2, 0, 1 in separate cycles:
  - Nothing commits until id 0 completes.
  - id 0 commits the cycle after its writeback.
  - ids 1 and 2 commit on the 2 following cycles with `prd` 6 and 7 and `needprf2arf`=1.
- Fill all 16 entries:
  - `di_i_ready`=0 and `count_o`=16.
  - Write back head: commit next cycle, `di_i_ready`=1 the cycle after.
  - Allocate 20 more instructions with immediate writebacks: `rob_id_o` wraps 15→0 and order is preserved.
- Same cycle allocate and commit at `count_o`=5: `count_o` stays 5; tail and head both advance.
- `flush_i` with 8 entries, one of them (the head) completed, plus a simultaneous allocate and writeback:
  - Next cycle `count_o`=0 and `rob_id_o`=0.
  - No commit in the flush cycle.
- Writeback to an unallocated id 9 while empty: no state change, `count_o`=0, assertion fires under `ROB_TRACE_EN`.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: in-order allocate from rename, out-of-order completion, in-order commit.
// Optional ROB_TRACE_EN adds per-event trace prints and occupancy/writeback assertions.
package rob_pkg;

  typedef struct packed {
    logic rd_valid;
  } si_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [4:0]  rd;
    logic [5:0]  prd;
    logic        fault;
    si_t         si;
  } di_t;

  typedef struct packed {
    logic        valid;
    logic        completed;
    logic [7:0]  id;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  prd;
    logic        needprf2arf;
    logic        fault;
  } rob_entry_t;

endpackage

module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE    = 16,
  parameter int ROB_ID_BITS = $clog2(ROB_SIZE)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  di_t                    di_i,
  input  logic                   di_i_valid,
  output logic                   di_i_ready,
  output logic [ROB_ID_BITS-1:0] rob_id_o,
  input  logic                   wb_valid_i,
  input  logic [ROB_ID_BITS-1:0] wb_rob_id_i,
  input  logic                   flush_i,
  output rob_entry_t             commit_entry_o,
  output logic [ROB_ID_BITS:0]   count_o
);

  localparam logic [ROB_ID_BITS:0] PTR_ONE = 1;

  logic [ROB_ID_BITS:0]   head_q;
  logic [ROB_ID_BITS:0]   tail_q;
  logic [ROB_ID_BITS-1:0] head_idx;
  logic [ROB_ID_BITS-1:0] tail_idx;
  rob_entry_t             ent_q [ROB_SIZE];

  logic full;
  logic fire;
  logic wb_ok;
  logic commit;

  assign head_idx = head_q[ROB_ID_BITS-1:0];
  assign tail_idx = tail_q[ROB_ID_BITS-1:0];

  assign full = (head_idx == tail_idx) &&
                (head_q[ROB_ID_BITS] != tail_q[ROB_ID_BITS]);

  assign di_i_ready = !full && !flush_i;
  assign fire       = di_i_valid && di_i_ready;
  assign rob_id_o   = tail_idx;
  assign count_o    = tail_q - head_q;

  assign wb_ok = wb_valid_i && ent_q[wb_rob_id_i].valid;

  // Gated by rstn and flush so rename never frees a register spuriously.
  assign commit = rstn && !flush_i &&
                  ent_q[head_idx].valid &&
                  ent_q[head_idx].completed;

  always_comb begin
    commit_entry_o           = ent_q[head_idx];
    commit_entry_o.completed = commit;
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_q[i].valid     <= 1'b0;
        ent_q[i].completed <= 1'b0;
      end
    end else begin
      if (fire) begin
        ent_q[tail_idx] <= '{
          valid:       1'b1,
          completed:   1'b0,
          id:          di_i.id,
          pc:          di_i.pc,
          rd:          di_i.rd,
          prd:         di_i.prd,
          needprf2arf: di_i.si.rd_valid,
          fault:       di_i.fault
        };
        tail_q <= tail_q + PTR_ONE;
      end
      if (wb_ok) begin
        ent_q[wb_rob_id_i].completed <= 1'b1;
      end
      if (commit) begin
        ent_q[head_idx].valid     <= 1'b0;
        ent_q[head_idx].completed <= 1'b0;
        head_q <= head_q + PTR_ONE;
      end
    end
  end

`ifdef ROB_TRACE_EN
  always @(posedge clk) begin
    if (rstn && !flush_i) begin
      if (fire)
        $display("rob alloc  pc=%h id=%0d idx=%0d rd=%0d prd=%0d fault=%b",
                 di_i.pc, di_i.id, tail_idx, di_i.rd, di_i.prd, di_i.fault);
      if (wb_valid_i) begin
        assert (ent_q[wb_rob_id_i].valid)
          else $error("rob: writeback to invalid entry %0d", wb_rob_id_i);
        if (wb_ok)
          $display("rob wb     pc=%h id=%0d idx=%0d rd=%0d prd=%0d fault=%b",
                   ent_q[wb_rob_id_i].pc, ent_q[wb_rob_id_i].id, wb_rob_id_i,
                   ent_q[wb_rob_id_i].rd, ent_q[wb_rob_id_i].prd,
                   ent_q[wb_rob_id_i].fault);
      end
      if (commit)
        $display("rob commit pc=%h id=%0d idx=%0d rd=%0d prd=%0d fault=%b",
                 commit_entry_o.pc, commit_entry_o.id, head_idx,
                 commit_entry_o.rd, commit_entry_o.prd, commit_entry_o.fault);
    end
    if (rstn)
      assert (int'(count_o) <= ROB_SIZE)
        else $error("rob: occupancy %0d exceeds size", count_o);
  end
`endif

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: reset, in-order commit, full/wrap,
// same-cycle alloc+commit, flush, stray writeback and mid-run reset.
module tb_rob;
  import rob_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  di_t        di = '0;
  logic       di_valid = 1'b0;
  logic       ready;
  logic [3:0] rid;
  logic       wb_valid = 1'b0;
  logic [3:0] wb_id = '0;
  logic       flush = 1'b0;
  rob_entry_t ce;
  logic [4:0] cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rob dut (
    .clk            (clk),
    .rstn           (rstn),
    .di_i           (di),
    .di_i_valid     (di_valid),
    .di_i_ready     (ready),
    .rob_id_o       (rid),
    .wb_valid_i     (wb_valid),
    .wb_rob_id_i    (wb_id),
    .flush_i        (flush),
    .commit_entry_o (ce),
    .count_o        (cnt)
  );

  function automatic di_t mk(logic [31:0] pc, logic [5:0] prd, logic f);
    di_t d;
    d = '0;
    d.pc = pc;
    d.id = pc[9:2];
    d.rd = prd[4:0];
    d.prd = prd;
    d.fault = f;
    d.si.rd_valid = 1'b1;
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready c=%0d got %b want 1", c, ready); end
      n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL reset_count c=%0d got %0d want 0", c, cnt); end
      n_chk++; if (rid !== 4'd0) begin n_fail++; $display("FAIL reset_robid c=%0d got %0d want 0", c, rid); end
      n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL reset_commit c=%0d got %b want 0", c, ce.completed); end
      tick();
    end
  endtask

  task automatic test_inorder;
    logic [3:0] ids [3];
    ids[0] = 4'd2; ids[1] = 4'd0; ids[2] = 4'd1;
    for (int i = 0; i < 3; i++) begin
      di = mk(32'h100 + 32'(4 * i), 6'(5 + i), i == 1);
      di_valid = 1'b1;
      #1;
      n_chk++; if (rid !== 4'(i)) begin n_fail++; $display("FAIL io_alloc_id got %0d want %0d", rid, i); end
      tick();
    end
    di_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd3) begin n_fail++; $display("FAIL io_count got %0d want 3", cnt); end
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1;
      wb_id = ids[k];
      #1;
      n_chk++; if (ce.completed !== (k == 2)) begin n_fail++; $display("FAIL io_commit k=%0d got %b want %b", k, ce.completed, k == 2); end
      if (k == 2) begin
        n_chk++; if (ce.prd !== 6'd5) begin n_fail++; $display("FAIL io_prd0 got %0d want 5", ce.prd); end
      end
      tick();
    end
    wb_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      #1;
      n_chk++; if (ce.completed !== 1'b1) begin n_fail++; $display("FAIL io_commit_n k=%0d got %b want 1", k, ce.completed); end
      n_chk++; if (ce.prd !== 6'(5 + k)) begin n_fail++; $display("FAIL io_prd k=%0d got %0d want %0d", k, ce.prd, 5 + k); end
      n_chk++; if (ce.needprf2arf !== 1'b1) begin n_fail++; $display("FAIL io_need k=%0d got %b want 1", k, ce.needprf2arf); end
      n_chk++; if (ce.fault !== (k == 1)) begin n_fail++; $display("FAIL io_fault k=%0d got %b want %b", k, ce.fault, k == 1); end
      tick();
    end
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL io_idle got %b want 0", ce.completed); end
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL io_empty got %0d want 0", cnt); end
  endtask

  task automatic test_full;
    logic [3:0] e;
    for (int i = 0; i < 16; i++) begin
      di = mk(32'h2000 + 32'(4 * i), 6'(i), 1'b0);
      di_valid = 1'b1;
      e = 4'((3 + i) % 16);
      #1;
      n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready i=%0d got %b want 1", i, ready); end
      n_chk++; if (rid !== e) begin n_fail++; $display("FAIL fill_id i=%0d got %0d want %0d", i, rid, e); end
      tick();
    end
    di_valid = 1'b0;
    #1;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", ready); end
    n_chk++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", cnt); end
    wb_valid = 1'b1;
    wb_id = 4'd3;
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL full_early got %b want 0", ce.completed); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_chk++; if (ce.completed !== 1'b1) begin n_fail++; $display("FAIL full_commit got %b want 1", ce.completed); end
    n_chk++; if (ce.pc !== 32'h2000) begin n_fail++; $display("FAIL full_pc got %h want 2000", ce.pc); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_commit got %b want 0", ready); end
    tick();
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL freed_ready got %b want 1", ready); end
    n_chk++; if (cnt !== 5'd15) begin n_fail++; $display("FAIL freed_count got %0d want 15", cnt); end
    for (int j = 0; j < 16; j++) begin
      wb_valid = (j < 15);
      wb_id = 4'((4 + j) % 16);
      #1;
      n_chk++; if (ce.completed !== (j > 0)) begin n_fail++; $display("FAIL drain_commit j=%0d got %b want %b", j, ce.completed, j > 0); end
      if (j > 0) begin
        n_chk++; if (ce.pc !== 32'h2000 + 32'(4 * j)) begin n_fail++; $display("FAIL drain_pc j=%0d got %h want %h", j, ce.pc, 32'h2000 + 32'(4 * j)); end
      end
      tick();
    end
    wb_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL drain_empty got %0d want 0", cnt); end
    for (int k = 0; k < 22; k++) begin
      di_valid = (k < 20);
      di = mk(32'h3000 + 32'(4 * k), 6'(k), 1'b0);
      wb_valid = (k >= 1 && k <= 20);
      wb_id = 4'((3 + k + 15) % 16);
      e = 4'((3 + k) % 16);
      #1;
      if (k < 20) begin
        n_chk++; if (rid !== e) begin n_fail++; $display("FAIL wrap_id k=%0d got %0d want %0d", k, rid, e); end
      end
      n_chk++; if (ce.completed !== (k >= 2)) begin n_fail++; $display("FAIL wrap_commit k=%0d got %b want %b", k, ce.completed, k >= 2); end
      if (k >= 2) begin
        n_chk++; if (ce.pc !== 32'h3000 + 32'(4 * (k - 2))) begin n_fail++; $display("FAIL wrap_pc k=%0d got %h want %h", k, ce.pc, 32'h3000 + 32'(4 * (k - 2))); end
      end
      tick();
    end
    di_valid = 1'b0;
    wb_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL wrap_empty got %0d want 0", cnt); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      di = mk(32'h4000 + 32'(4 * i), 6'(i), 1'b0);
      di_valid = 1'b1;
      tick();
    end
    di_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd5) begin n_fail++; $display("FAIL b2b_count0 got %0d want 5", cnt); end
    wb_valid = 1'b1;
    wb_id = 4'd7;
    tick();
    wb_valid = 1'b0;
    di = mk(32'h4014, 6'd5, 1'b0);
    di_valid = 1'b1;
    #1;
    n_chk++; if (ce.completed !== 1'b1) begin n_fail++; $display("FAIL b2b_commit got %b want 1", ce.completed); end
    n_chk++; if (ce.pc !== 32'h4000) begin n_fail++; $display("FAIL b2b_pc got %h want 4000", ce.pc); end
    n_chk++; if (rid !== 4'd12) begin n_fail++; $display("FAIL b2b_id0 got %0d want 12", rid); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready); end
    tick();
    di_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd5) begin n_fail++; $display("FAIL b2b_count1 got %0d want 5", cnt); end
    n_chk++; if (rid !== 4'd13) begin n_fail++; $display("FAIL b2b_id1 got %0d want 13", rid); end
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", ce.completed); end
    n_chk++; if (ce.pc !== 32'h4004) begin n_fail++; $display("FAIL b2b_head got %h want 4004", ce.pc); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      di = mk(32'h4018 + 32'(4 * i), 6'(i), 1'b0);
      di_valid = 1'b1;
      tick();
    end
    di_valid = 1'b0;
    wb_valid = 1'b1;
    wb_id = 4'd8;
    #1;
    n_chk++; if (cnt !== 5'd8) begin n_fail++; $display("FAIL fl_count8 got %0d want 8", cnt); end
    tick();
    flush = 1'b1;
    di = mk(32'h4100, 6'd9, 1'b0);
    di_valid = 1'b1;
    wb_id = 4'd9;
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL fl_commit got %b want 0", ce.completed); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b want 0", ready); end
    tick();
    flush = 1'b0;
    di_valid = 1'b0;
    wb_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL fl_count got %0d want 0", cnt); end
    n_chk++; if (rid !== 4'd0) begin n_fail++; $display("FAIL fl_id got %0d want 0", rid); end
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL fl_post got %b want 0", ce.completed); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready1 got %b want 1", ready); end
    tick();
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL fl_post2 got %b want 0", ce.completed); end
  endtask

  task automatic test_bad_wb;
    wb_valid = 1'b1;
    wb_id = 4'd9;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL bad_count0 got %0d want 0", cnt); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL bad_count1 got %0d want 0", cnt); end
    n_chk++; if (rid !== 4'd0) begin n_fail++; $display("FAIL bad_id got %0d want 0", rid); end
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL bad_commit got %b want 0", ce.completed); end
    di = mk(32'h5000, 6'd12, 1'b0);
    di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    wb_valid = 1'b1;
    wb_id = 4'd0;
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", ce.completed); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_chk++; if (ce.completed !== 1'b1) begin n_fail++; $display("FAIL lat_commit got %b want 1", ce.completed); end
    n_chk++; if (ce.pc !== 32'h5000) begin n_fail++; $display("FAIL lat_pc got %h want 5000", ce.pc); end
    tick();
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL lat_empty got %0d want 0", cnt); end
  endtask

  task automatic test_reset_mid;
    di = mk(32'h6000, 6'd3, 1'b0);
    di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    wb_valid = 1'b1;
    wb_id = 4'd1;
    tick();
    wb_valid = 1'b0;
    rstn = 1'b0;
    #1;
    n_chk++; if (ce.completed !== 1'b0) begin n_fail++; $display("FAIL rst_commit got %b want 0", ce.completed); end
    tick();
    rstn = 1'b1;
    #1;
    n_chk++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", cnt); end
    n_chk++; if (rid !== 4'd0) begin n_fail++; $display("FAIL rst_id got %0d want 0", rid); end
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ready); end
  endtask

  initial begin
    test_reset();
    test_inorder();
    test_full();
    test_back_to_back();
    test_flush();
    test_bad_wb();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
